// File: rtl/mux3_arbiter.sv
// rtl/mux3_arbiter.sv - three-requester arbiter driving a registered 3:1 mux select and output stage
// Fixed-priority or round-robin ownership, bounded bursts, single valid/ready output register.
module mux3_arbiter #(
    parameter int DW        = 8,
    parameter int MODE      = 0,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    req,
    input  logic [DW-1:0] din_a,
    input  logic [DW-1:0] din_b,
    input  logic [DW-1:0] din_c,
    output logic [2:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;

    logic          can_load;
    logic [2:0]    own_oh;
    logic          own_req;
    logic [DW-1:0] own_din;
    logic [1:0]    fixed_pick;
    logic [1:0]    rr_pick;
    logic [1:0]    rr_start;

    assign can_load = !dout_valid_q || dout_ready;

    always_comb begin
        own_oh  = 3'b001;
        own_din = din_a;
        unique case (sel_q)
            2'd1: begin
                own_oh  = 3'b010;
                own_din = din_b;
            end
            2'd2: begin
                own_oh  = 3'b100;
                own_din = din_c;
            end
            default: begin
                own_oh  = 3'b001;
                own_din = din_a;
            end
        endcase
    end

    assign own_req = |(req & own_oh);

    // Winner encoders are only consulted when some req bit is set, so the final fallback is safe.
    always_comb begin
        fixed_pick = 2'd2;
        if (req[0]) begin
            fixed_pick = 2'd0;
        end else if (req[1]) begin
            fixed_pick = 2'd1;
        end
    end

    assign rr_start = (last_q >= 2'd2) ? 2'd0 : last_q + 2'd1;

    always_comb begin
        rr_pick = 2'd0;
        unique case (rr_start)
            2'd1:    rr_pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    rr_pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: rr_pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        gnt          = 3'b000;

        unique case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    sel_d   = (MODE == 1) ? rr_pick : fixed_pick;
                    cnt_d   = 4'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (own_req && can_load) begin
                    gnt          = own_oh;
                    dout_d       = own_din;
                    dout_valid_d = 1'b1;
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == BURST_LAST) begin
                        last_d  = sel_q;
                        state_d = IDLE;
                    end
                end else if (!own_req && can_load) begin
                    // Owner dropped its request: give up the mux without a beat.
                    last_d  = sel_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 2'b00;
            last_q       <= 2'b10;
            cnt_q        <= 4'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux3_arbiter.sv
// tb/tb_mux3_arbiter.sv - directed scoreboard bench for mux3_arbiter in fixed and round-robin modes
module tb_mux3_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [7:0] din_a, din_b, din_c;
    logic       dout_ready;

    logic [2:0] gnt0, gnt1;
    logic [1:0] sel0, sel1;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         rem[3];
    logic [7:0] seq[3];
    bit         act;
    string      phase;
    logic [7:0] obs_dout;
    logic       obs_dv;
    logic [7:0] hold_val;

    always #5 clk = ~clk;

    mux3_arbiter #(.DW(8), .MODE(0), .MAX_BURST(4)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din_a(din_a), .din_b(din_b), .din_c(din_c),
        .gnt(gnt0), .sel(sel0), .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready)
    );

    mux3_arbiter #(.DW(8), .MODE(1), .MAX_BURST(4)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din_a(din_a), .din_b(din_b), .din_c(din_c),
        .gnt(gnt1), .sel(sel1), .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
            $error("check %s/%s", phase, tag);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < 3; i++) req[i] = (rem[i] != 0);
        din_a = 8'h10 + seq[0];
        din_b = 8'h40 + seq[1];
        din_c = 8'h80 + seq[2];
    endtask

    task automatic set_rem(input int a, input int b, input int c);
        rem[0] = a;
        rem[1] = b;
        rem[2] = c;
        apply();
    endtask

    task automatic chk_reset_all();
        chk("rst_gnt_u0", 32'(gnt0), 0);
        chk("rst_sel_u0", 32'(sel0), 0);
        chk("rst_dv_u0", 32'(dv0), 0);
        chk("rst_dout_u0", 32'(dout0), 0);
        chk("rst_gnt_u1", 32'(gnt1), 0);
        chk("rst_sel_u1", 32'(sel1), 0);
        chk("rst_dv_u1", 32'(dv1), 0);
        chk("rst_dout_u1", 32'(dout1), 0);
    endtask

    // One clock: check grant/select, retire an output beat, record requester-side transfers.
    task automatic step(input logic [2:0] eg, input logic [1:0] es);
        logic [2:0] g, x;
        logic [1:0] s;
        logic       dv;
        logic [7:0] dq;
        @(negedge clk);
        chk("onehot_u0", 32'($onehot0(gnt0)), 1);
        chk("onehot_u1", 32'($onehot0(gnt1)), 1);
        chk("sel_legal_u0", 32'(sel0 != 2'b11), 1);
        chk("sel_legal_u1", 32'(sel1 != 2'b11), 1);
        g  = act ? gnt1 : gnt0;
        s  = act ? sel1 : sel0;
        dv = act ? dv1 : dv0;
        dq = act ? dout1 : dout0;
        chk("gnt", 32'(g), 32'(eg));
        chk("sel", 32'(s), 32'(es));
        obs_dout = dq;
        obs_dv   = dv;
        if (dv && dout_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 1);
            else chk("dout", 32'(dq), 32'(exp_q.pop_front()));
        end
        x = req & g;
        if (x[0]) exp_q.push_back(din_a);
        if (x[1]) exp_q.push_back(din_b);
        if (x[2]) exp_q.push_back(din_c);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (x[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
        apply();
    endtask

    initial begin
        rst_n      = 1'b0;
        dout_ready = 1'b1;
        act        = 1'b0;
        phase      = "init";
        for (int i = 0; i < 3; i++) seq[i] = 8'd0;
        set_rem(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        phase = "reset";
        set_rem(100, 100, 100);
        step(3'b000, 2'b00);
        step(3'b001, 2'b00);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_all();
        repeat (3) begin
            step(3'b000, 2'b00);
            chk("dv_hold", 32'(obs_dv), 0);
            chk("dout_hold", 32'(obs_dout), 0);
        end
        set_rem(0, 0, 0);
        rst_n = 1'b1;

        phase = "fixed";
        set_rem(8, 8, 8);
        step(3'b000, 2'b00);
        repeat (4) step(3'b001, 2'b00);
        step(3'b000, 2'b00);
        repeat (4) step(3'b001, 2'b00);
        step(3'b000, 2'b00);
        repeat (2) step(3'b010, 2'b01);
        set_rem(0, 0, 0);
        step(3'b000, 2'b01);
        step(3'b000, 2'b01);
        chk("sb_empty", 32'(exp_q.size()), 0);

        phase = "rr";
        act   = 1'b1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rem(8, 4, 4);
        step(3'b000, 2'b00);
        repeat (4) step(3'b001, 2'b00);
        step(3'b000, 2'b00);
        repeat (4) step(3'b010, 2'b01);
        step(3'b000, 2'b01);
        repeat (4) step(3'b100, 2'b10);
        step(3'b000, 2'b10);
        repeat (4) step(3'b001, 2'b00);
        step(3'b000, 2'b00);
        chk("sb_empty", 32'(exp_q.size()), 0);

        phase = "bp";
        set_rem(0, 4, 0);
        step(3'b000, 2'b00);
        step(3'b010, 2'b01);
        step(3'b010, 2'b01);
        hold_val   = 8'h40 + seq[1] - 8'd1;
        dout_ready = 1'b0;
        repeat (3) begin
            step(3'b000, 2'b01);
            chk("bp_dv", 32'(obs_dv), 1);
            chk("bp_dout", 32'(obs_dout), 32'(hold_val));
        end
        dout_ready = 1'b1;
        step(3'b010, 2'b01);
        step(3'b010, 2'b01);
        step(3'b000, 2'b01);
        chk("sb_empty", 32'(exp_q.size()), 0);

        phase = "early";
        set_rem(4, 4, 2);
        step(3'b000, 2'b01);
        repeat (2) step(3'b100, 2'b10);
        step(3'b000, 2'b10);
        step(3'b000, 2'b10);
        repeat (4) step(3'b001, 2'b00);
        step(3'b000, 2'b00);
        repeat (4) step(3'b010, 2'b01);
        step(3'b000, 2'b01);
        chk("sb_empty", 32'(exp_q.size()), 0);

        phase = "rst_mid";
        set_rem(0, 8, 0);
        step(3'b000, 2'b01);
        step(3'b010, 2'b01);
        step(3'b010, 2'b01);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        rem[2] = 8;
        apply();
        #1;
        chk_reset_all();
        repeat (2) step(3'b000, 2'b00);
        rst_n = 1'b1;
        step(3'b000, 2'b00);
        step(3'b010, 2'b01);
        step(3'b010, 2'b01);
        set_rem(0, 0, 0);
        step(3'b000, 2'b01);
        step(3'b000, 2'b01);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux3_arbiter.md
# mux3_arbiter

Three-requester arbiter and sequencer for the 3:1 select mux in the datapath. It decides which requester owns the mux and drives the registered `sel` code. It returns per-requester grants and registers the muxed beat into a single valid/ready output stage. It supports fixed-priority or round-robin ownership with a bounded burst length, and it never drives the uncovered select code 2'b11.

## Interface
- `DW`, 8: data width of each mux input and the output.
- `MODE`, 0: ownership policy. 0 = fixed priority (0 > 1 > 2); 1 = round robin.
- `MAX_BURST`, 4: maximum beats per ownership; legal range 1..15.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  per-requester valid; must stay high, with stable `din_*`, until the matching `gnt` bit is seen.
- `din_a`, `din_b`, `din_c`  in  DW each  requester data (mux inputs 0, 1, 2).
- `gnt`  out  3  one-hot per-requester ready (Mealy); a beat transfers on cycles where `req[i]` and `gnt[i]` are both high.
- `sel`  out  2  registered mux select; legal values are 2'b00 to 2'b10 only.
- `dout`  out  DW  registered output beat.
- `dout_valid`  out  1  output stage holds a beat.
- `dout_ready`  in  1  downstream accept.

## Operation
- States: IDLE and BUSY. Registers: `owner`/`sel`, `last` (round-robin pointer), `cnt` (4 bits), `dout`, `dout_valid`.
- `can_load = !dout_valid || dout_ready`.
- **IDLE**
  - If `req` is 3'b000, stay in IDLE.
  - Otherwise pick a winner, load `sel` with the winner, clear `cnt`, and go to BUSY. `gnt` stays low in IDLE.
  - Fixed priority: the lowest-index asserted `req` wins.
  - Round robin: search starts at (`last`+1) mod 3 and wraps, so 2 is followed by 0.
- **BUSY** (owner o = `sel`)
  - `gnt[o] = req[o] && can_load`; other `gnt` bits are 0.
  - On a transfer: `dout <= din_o`, `dout_valid <= 1`, `cnt <= cnt+1`.
  - If `cnt+1 == MAX_BURST` on a transfer: set `last <= o` and go to IDLE.
  - If `req[o]` is low and `can_load` is high: release without a transfer, set `last <= o`, and go to IDLE.
  - If `req[o]` is high but `can_load` is low: hold. Ownership and `cnt` are unchanged.
- **Output stage**
  - When `dout_valid && dout_ready` and there is no new load, clear `dout_valid`.
  - `dout` is stable while `dout_valid && !dout_ready`.
- `sel` holds its last value while in IDLE and is never 2'b11. Fixed priority ignores `last`.
- At most one `gnt` bit is high in any cycle. The bench asserts this every cycle.

## Timing
- **Reset values** (immediate, asynchronous, independent of `clk`):
  - state IDLE, `sel` 2'b00, `last` 2'b10, `cnt` 0, `dout` 0, `dout_valid` 0.
  - `gnt` reads 3'b000.
- Arbitration takes one cycle. With `req` rising at edge N, `sel` updates at N+1. If `can_load` holds, `gnt` is high during cycle N+1 and `dout_valid` rises at N+2.
- Sustained throughput is one beat per cycle within a burst.
- There is one idle cycle (no `gnt`) between consecutive ownerships.
- A burst of B beats with no backpressure occupies B+1 cycles including arbitration.
- If a requester raises `req` during another requester's burst, it waits for the release. It is not pre-empted.
- **Reset mid-burst:** a beat held in `dout` is dropped. `dout_valid` falls immediately, and the round-robin history is lost.
- **Release and new request in the same cycle:** the release wins. The new arbitration happens in the following IDLE cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle with `req`=3'b111. Required: `sel`=0, `gnt`=0, `dout_valid`=0, `dout`=0 asynchronously, held until release.
- **Fixed priority** (MODE=0, MAX_BURST=4): `req`=3'b111 held, `dout_ready`=1. Required: owner 0 for 4 beats, one idle cycle, then owner 0 again; `sel` never leaves 2'b00; `dout` = `din_a` values in order.
- **Round robin** (MODE=1, MAX_BURST=4): `req`=3'b111 held. Required: grant order 0, 1, 2, 0. Each owner gets 4 consecutive `gnt` cycles with a 1-cycle gap, and `sel` cycles 00 → 01 → 10 → 00.
- **Backpressure:** owner 1 streaming; set `dout_ready`=0 for 3 cycles. Required: `gnt` low for those cycles, `dout` and `dout_valid` stable, `cnt` frozen; streaming resumes on the first cycle `dout_ready`=1 with no lost or duplicated beat.
- **Early release** (MODE=1): `req[2]` drops after 2 beats while `req[0]` is high. Required: IDLE for one cycle, then `sel`=00 and `gnt[0]` high; `last`=2.
- **Async reset mid-burst:** pulse `rst_n` low during beat 2 of owner 1. Required: immediate reset values. After release with `req`=3'b110, MODE=1, owner 1 wins (the search starts at 0, and `req[0]` is low).
